// File: rtl/qspi_cmd_sequencer.sv
// QSPI frame builder: splits one opcode/address/dummy/payload request into per-byte master transfers.
// Optional watchdog on missing m_byte_done: define QSPI_SEQ_TIMEOUT_EN.
module qspi_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 9
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_opcode,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_addr_en,
  input  logic [1:0]            req_addr_mode,
  input  logic [1:0]            req_data_mode,
  input  logic [3:0]            req_dummy,
  input  logic                  req_write,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [7:0]            wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [7:0]            rdata,
  output logic                  rdata_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] m_wr_data,
  output logic [1:0]            m_sel_mode,
  output logic                  m_operation,
  output logic                  m_trigger,
  output logic                  m_cs_hold,
  input  logic                  m_byte_done,
  input  logic [DATA_WIDTH-1:0] m_rd_data
);
  localparam int ADDR_BYTES = ADDR_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_ERR} state_t;

  state_t                r_state, w_next;
  logic                  r_wait, r_trig, r_op;
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_addr_en, r_write;
  logic [1:0]            r_addr_mode, r_data_mode;
  logic [3:0]            r_dummy;
  logic [LEN_W-1:0]      r_len, r_cnt;
  logic                  w_rsvd, w_wr_fire, w_rd_fire, w_last, w_abort;

  assign w_rsvd    = (req_addr_en && req_addr_mode == 2'b11) ||
                     (req_data_mode == 2'b11 && (req_dummy != 4'd0 || req_len != '0));
  assign w_wr_fire = wdata_ready && wdata_valid;
  assign w_rd_fire = (r_state == S_DATA) && !r_write && r_wait && m_byte_done;
  assign w_last    = (r_state == S_CMD) || (r_cnt == LEN_W'(1));

  always_comb begin
    w_next = S_DONE;
    if (r_state == S_CMD && r_addr_en)                                   w_next = S_ADDR;
    else if ((r_state == S_CMD || r_state == S_ADDR) && r_dummy != 4'd0) w_next = S_DUMMY;
    else if (r_state != S_DATA && r_len != '0)                           w_next = S_DATA;
  end

`ifdef QSPI_SEQ_TIMEOUT_EN
  // Only counts while a triggered byte is outstanding, so write-stream stalls are free.
  logic [15:0] r_wdog;
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                          r_wdog <= '0;
    else if (r_wait && !m_byte_done)  r_wdog <= r_wdog + 16'd1;
    else                              r_wdog <= '0;
  end
  assign w_abort = r_wait && !m_byte_done && (r_wdog == 16'hFFFE);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;  r_wait <= 1'b0;  r_trig <= 1'b0;  r_op <= 1'b0;
      r_mode <= '0;  r_wr_data <= '0;  r_addr <= '0;  r_addr_en <= 1'b0;
      r_write <= 1'b0;  r_addr_mode <= '0;  r_data_mode <= '0;  r_dummy <= '0;
      r_len <= '0;  r_cnt <= '0;
    end else begin
      r_trig <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr <= req_addr;  r_addr_en <= req_addr_en;  r_addr_mode <= req_addr_mode;
          r_data_mode <= req_data_mode;  r_dummy <= req_dummy;  r_write <= req_write;
          r_len <= req_len;
          if (w_rsvd) r_state <= S_ERR;
          else begin
            r_state <= S_CMD;  r_trig <= 1'b1;  r_wait <= 1'b1;
            r_wr_data <= DATA_WIDTH'(req_opcode);  r_mode <= 2'b00;  r_op <= 1'b1;
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (w_abort) begin
            r_state <= S_ERR;  r_wait <= 1'b0;
          end else if (w_wr_fire) begin
            r_wait <= 1'b1;
          end else if (r_wait && m_byte_done) begin
            if (w_last) begin
              r_state <= w_next;
              case (w_next)
                S_ADDR: begin
                  r_trig <= 1'b1;  r_wait <= 1'b1;  r_op <= 1'b1;  r_mode <= r_addr_mode;
                  r_wr_data <= DATA_WIDTH'(r_addr[ADDR_W-1 -: 8]);  r_addr <= r_addr << 8;
                  r_cnt <= LEN_W'(ADDR_BYTES);
                end
                S_DUMMY: begin
                  r_trig <= 1'b1;  r_wait <= 1'b1;  r_op <= 1'b0;  r_mode <= r_data_mode;
                  r_wr_data <= '0;  r_cnt <= LEN_W'(r_dummy);
                end
                S_DATA: begin
                  // Writes wait for the stream; reads can start straight away.
                  r_trig <= !r_write;  r_wait <= !r_write;  r_op <= r_write;
                  r_mode <= r_data_mode;  r_wr_data <= '0;  r_cnt <= r_len;
                end
                default: r_wait <= 1'b0;
              endcase
            end else begin
              r_cnt <= r_cnt - 1'b1;
              if (r_state == S_ADDR) begin
                r_trig <= 1'b1;
                r_wr_data <= DATA_WIDTH'(r_addr[ADDR_W-1 -: 8]);  r_addr <= r_addr << 8;
              end else if (r_state == S_DATA && r_write) r_wait <= 1'b0;
              else r_trig <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;  r_wait <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign err         = (r_state == S_ERR);
  assign m_cs_hold   = (r_state == S_CMD) || (r_state == S_ADDR) ||
                       (r_state == S_DUMMY) || (r_state == S_DATA);
  assign wdata_ready = (r_state == S_DATA) && r_write && !r_wait;
  assign m_trigger   = r_trig || w_wr_fire;
  assign m_wr_data   = w_wr_fire ? DATA_WIDTH'(wdata) : r_wr_data;
  assign m_sel_mode  = r_mode;
  assign m_operation = r_op;
  assign rdata_valid = w_rd_fire;
  assign rdata       = w_rd_fire ? m_rd_data[7:0] : 8'h00;
endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// Bench for qspi_cmd_sequencer: master responder, write-stream feeder, frame-level reference model.
module tb_qspi_cmd_sequencer;
  logic        sys_clk = 1'b0;
  logic        rst, req_valid, req_ready, req_addr_en, req_write;
  logic [7:0]  req_opcode;
  logic [23:0] req_addr;
  logic [1:0]  req_addr_mode, req_data_mode;
  logic [3:0]  req_dummy;
  logic [8:0]  req_len;
  logic [7:0]  wdata, rdata, m_wr_data, m_rd_data;
  logic        wdata_valid, wdata_ready, rdata_valid, busy, done, err;
  logic [1:0]  m_sel_mode;
  logic        m_operation, m_trigger, m_cs_hold, m_byte_done;

  qspi_cmd_sequencer dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_addr(req_addr), .req_addr_en(req_addr_en),
    .req_addr_mode(req_addr_mode), .req_data_mode(req_data_mode), .req_dummy(req_dummy),
    .req_write(req_write), .req_len(req_len), .wdata(wdata), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
    .done(done), .err(err), .m_wr_data(m_wr_data), .m_sel_mode(m_sel_mode),
    .m_operation(m_operation), .m_trigger(m_trigger), .m_cs_hold(m_cs_hold),
    .m_byte_done(m_byte_done), .m_rd_data(m_rd_data));

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] opcode; logic [23:0] addr; bit addr_en; logic [1:0] amode, dmode;
    int dummy; bit write; int len; int lat; int stall_len; logic [7:0] w0, w1;
    int exp_n; int exp_cs; int exp_done; int exp_err;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Frame configuration shared with the responder and feeder (written only by the main block).
  int         frame_no = 0, lat_f = 1, stall_len_f = 0;
  logic [7:0] wbuf[$], rsp_buf[$];

  // Monitor: logs triggers, read bytes and pulse counts; never cleared, frames use deltas.
  logic [10:0] trig_q[$];
  int          trig_t[$];
  logic [7:0]  rd_q[$];
  int          done_cnt = 0, err_cnt = 0, cs_cnt = 0, err_t = 0;
  always @(negedge sys_clk) begin
    if (m_trigger) begin trig_q.push_back({m_operation, m_sel_mode, m_wr_data}); trig_t.push_back(cyc); end
    if (rdata_valid) rd_q.push_back(rdata);
    if (done) done_cnt++;
    if (err) begin err_cnt++; err_t = cyc; end
    if (m_cs_hold) cs_cnt++;
  end

  // Master model: byte_done lat_f cycles after each trigger; read bytes come from rsp_buf.
  initial begin
    int r_frame, r_i;
    logic [7:0] d;
    r_frame = -1; r_i = 0;
    m_byte_done = 1'b0; m_rd_data = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (r_frame != frame_no) begin r_frame = frame_no; r_i = 0; end
      if (m_trigger) begin
        d = 8'h5A;
        if (!m_operation && r_i < rsp_buf.size()) begin d = rsp_buf[r_i]; r_i++; end
        repeat (lat_f) @(posedge sys_clk);
        #1 m_byte_done = 1'b1; m_rd_data = d;
        @(posedge sys_clk);
        #1 m_byte_done = 1'b0; m_rd_data = 8'h00;
      end
    end
  end

  // Write stream feeder: presents wbuf in order, goes quiet stall_len_f cycles after byte 0.
  initial begin
    int f_frame, f_i, f_stall;
    f_frame = -1; f_i = 0; f_stall = 0;
    wdata_valid = 1'b0; wdata = 8'h00;
    forever begin
      @(posedge sys_clk); #1;
      if (f_frame != frame_no) begin f_frame = frame_no; f_i = 0; f_stall = 0; end
      if (f_stall > 0) begin f_stall--; wdata_valid = 1'b0; end
      else if (f_i < wbuf.size()) begin wdata_valid = 1'b1; wdata = wbuf[f_i]; end
      else wdata_valid = 1'b0;
      @(negedge sys_clk);
      if (wdata_valid && wdata_ready) begin f_i++; if (f_i == 1) f_stall = stall_len_f; end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_opcode = v.opcode; req_addr = v.addr; req_addr_en = v.addr_en;
    req_addr_mode = v.amode; req_data_mode = v.dmode; req_dummy = 4'(v.dummy);
    req_write = v.write; req_len = 9'(v.len);
  endtask

  // Runs one frame and compares it with a byte list built from the request fields.
  task automatic run_frame(input vec_t v, input bit rnd);
    logic [10:0] exp_t[$], a, e;
    logic [7:0]  exp_rd[$], wb[$], rb[$];
    bit rsvd, fin;
    int tb0, rd0, dn0, er0, cs0, acc, nrd;
    rsvd = (v.addr_en && v.amode == 2'b11) || (v.dmode == 2'b11 && (v.dummy != 0 || v.len != 0));
    for (int i = 0; i < v.len; i++)
      wb.push_back(i == 0 ? v.w0 : i == 1 ? v.w1 : 8'(i * 37));
    nrd = v.dummy + (v.write ? 0 : v.len);
    for (int k = 0; k < nrd; k++) rb.push_back(rnd ? 8'($urandom) : 8'(8'h11 * (k + 1)));
    if (!rsvd) begin
      exp_t.push_back({1'b1, 2'b00, v.opcode});
      if (v.addr_en) for (int b = 0; b < 3; b++) exp_t.push_back({1'b1, v.amode, 8'(v.addr >> (16 - 8 * b))});
      for (int d = 0; d < v.dummy; d++) exp_t.push_back({1'b0, v.dmode, 8'h00});
      for (int i = 0; i < v.len; i++) exp_t.push_back({v.write, v.dmode, v.write ? wb[i] : 8'h00});
      if (!v.write) for (int k = v.dummy; k < nrd; k++) exp_rd.push_back(rb[k]);
    end
    wbuf = wb; rsp_buf = rb; lat_f = v.lat; stall_len_f = v.stall_len; frame_no++;
    tb0 = trig_q.size(); rd0 = rd_q.size(); dn0 = done_cnt; er0 = err_cnt; cs0 = cs_cnt;
    @(posedge sys_clk); #1;
    drive_req(v); req_valid = 1'b1; acc = cyc;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge sys_clk);
      fin = (done_cnt != dn0) || (err_cnt != er0);
    end
    chk("frame_end_seen", int'(fin), 1);
    repeat (3) @(negedge sys_clk);
    chk("n_trig", trig_q.size() - tb0, v.exp_n);
    for (int i = 0; i < exp_t.size(); i++) begin
      if (tb0 + i < trig_q.size()) begin
        a = trig_q[tb0 + i]; e = exp_t[i];
        if (!e[10]) begin a[7:0] = 8'h00; e[7:0] = 8'h00; end
        chk($sformatf("trig%0d", i), int'(a), int'(e));
      end
    end
    chk("n_rdata", rd_q.size() - rd0, exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      if (rd0 + i < rd_q.size()) chk($sformatf("rdata%0d", i), int'(rd_q[rd0 + i]), int'(exp_rd[i]));
    chk("done_pulses", done_cnt - dn0, v.exp_done);
    chk("err_pulses", err_cnt - er0, v.exp_err);
    chk("cs_hold_cycles", cs_cnt - cs0, v.exp_cs);
    if (v.exp_n > 0 && trig_q.size() > tb0) chk("first_trig_lat", trig_t[tb0] - acc, 1);
    if (v.exp_err != 0) chk("err_lat", err_t - acc, 1);
    chk("req_ready_after", int'(req_ready), 1);
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    vec_t vt[7], vs, vr;
    int n, tb0, dn0, extra;
    bit rsvd, seen;
    rst = 1'b1; req_valid = 1'b0;
    vr = '{8'h00, 24'h0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0};
    drive_req(vr);
    // opcode addr en am dm dummy wr len lat stall w0 w1 | n cs done err
    vt[0] = '{8'h06, 24'h000000, 0, 2'b00, 2'b00, 0, 1, 0, 4, 0, 8'h00, 8'h00,  1,  5, 1, 0};
    vt[1] = '{8'h32, 24'h123456, 1, 2'b10, 2'b10, 0, 1, 2, 4, 0, 8'hAA, 8'h55,  6, 30, 1, 0};
    vt[2] = '{8'hEB, 24'h000010, 1, 2'b10, 2'b10, 2, 0, 3, 2, 0, 8'h00, 8'h00,  9, 27, 1, 0};
    vt[3] = '{8'h6B, 24'h000000, 0, 2'b00, 2'b11, 0, 0, 1, 2, 0, 8'h00, 8'h00,  0,  0, 0, 1};
    vt[4] = '{8'h03, 24'h000000, 1, 2'b11, 2'b00, 0, 0, 0, 2, 0, 8'h00, 8'h00,  0,  0, 0, 1};
    vt[5] = '{8'h9F, 24'h000000, 0, 2'b11, 2'b11, 0, 0, 0, 1, 0, 8'h00, 8'h00,  1,  2, 1, 0};
    vt[6] = '{8'h3B, 24'h000000, 0, 2'b00, 2'b01, 15, 0, 1, 1, 0, 8'h00, 8'h00, 17, 34, 1, 0};
    vs    = '{8'h02, 24'h00ABCD, 1, 2'b00, 2'b01, 0, 1, 2, 3, 10, 8'hC3, 8'h3C,  6, 31, 1, 0};

    repeat (3) @(negedge sys_clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_trigger", int'(m_trigger), 0);
    chk("rst_cs_hold", int'(m_cs_hold), 0);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_wdata_ready", int'(wdata_ready), 0);
    chk("rst_rdata", int'({rdata_valid, rdata}), 0);
    chk("rst_master_out", int'({m_operation, m_sel_mode, m_wr_data}), 0);
    @(posedge sys_clk); #1 rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    foreach (vt[i]) run_frame(vt[i], 1'b0);

    // Write stream stalls 10 cycles before byte 2: no trigger meanwhile, CS held throughout.
    run_frame(vs, 1'b0);
    n = trig_q.size();
    if (n >= 2) chk("stall_trig_gap", trig_t[n - 1] - trig_t[n - 2], 11);
    else chk("stall_trig_count", n, 2);

    // Reset during ADDR aborts the frame immediately and suppresses done.
    vr = '{8'h0B, 24'hFEDCBA, 1, 2'b00, 2'b00, 0, 0, 0, 4, 0, 8'h00, 8'h00, 0, 0, 0, 0};
    wbuf.delete(); rsp_buf.delete(); lat_f = 4; stall_len_f = 0; frame_no++;
    tb0 = trig_q.size(); dn0 = done_cnt; seen = 1'b0;
    @(posedge sys_clk); #1 drive_req(vr); req_valid = 1'b1;
    @(posedge sys_clk); #1 req_valid = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge sys_clk);
      seen = (trig_q.size() >= tb0 + 2);
    end
    chk("addr_phase_reached", int'(seen), 1);
    @(posedge sys_clk); #1 rst = 1'b1;
    @(posedge sys_clk); #1 rst = 1'b0;
    @(negedge sys_clk);
    chk("midrst_cs_hold", int'(m_cs_hold), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_req_ready", int'(req_ready), 1);
    repeat (20) @(negedge sys_clk);
    chk("midrst_no_done", done_cnt - dn0, 0);

    // Random frames against the frame-level model.
    for (int r = 0; r < 14; r++) begin
      vr.opcode = 8'($urandom); vr.addr = 24'($urandom); vr.addr_en = 1'($urandom);
      vr.amode = 2'($urandom_range(0, 3)); vr.dmode = 2'($urandom_range(0, 3));
      vr.dummy = $urandom_range(0, 3); vr.write = 1'($urandom); vr.len = $urandom_range(0, 5);
      vr.lat = $urandom_range(1, 5); vr.stall_len = vr.write ? $urandom_range(0, 8) : 0;
      vr.w0 = 8'($urandom); vr.w1 = 8'($urandom);
      rsvd = (vr.addr_en && vr.amode == 2'b11) || (vr.dmode == 2'b11 && (vr.dummy != 0 || vr.len != 0));
      extra = (vr.write && vr.len > 1 && vr.stall_len > vr.lat) ? vr.stall_len - vr.lat : 0;
      vr.exp_n    = rsvd ? 0 : 1 + (vr.addr_en ? 3 : 0) + vr.dummy + vr.len;
      vr.exp_cs   = rsvd ? 0 : vr.exp_n * (vr.lat + 1) + extra;
      vr.exp_done = rsvd ? 0 : 1;
      vr.exp_err  = rsvd ? 1 : 0;
      run_frame(vr, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
